// File: rtl/spatz_tcdm_adapter_pkg.sv
// Shared types and constants for the Spatz x_mem to TCDM adapter.
package spatz_tcdm_adapter_pkg;

    localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
    localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ERR  = 1'b1
    } state_e;

    // The access size is at most 8 bytes, so only the three address LSBs matter.
    function automatic logic is_aligned(input logic [2:0] addr_lsb,
                                        input logic [1:0] size,
                                        input int unsigned max_size);
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return (32'(size) <= max_size) && ((addr_lsb & mask) == 3'd0);
    endfunction

endpackage

// File: rtl/spatz_tcdm_adapter_fifo.sv
// Fall-through FIFO holding per-request metadata; head is visible combinationally.
module spatz_tcdm_adapter_fifo #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             empty_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CntWidth-1:0] count_reg, count_next;
    logic [Width-1:0]    mem_reg [Depth];
    logic                do_push, do_pop;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pop is evaluated first so a full FIFO can take a push in the same cycle it pops.
    assign do_pop  = pop_i && (count_reg != '0);
    assign do_push = push_i && ((count_reg != CntWidth'(Depth)) || do_pop);

    always_comb begin
        wr_ptr_next = do_push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = do_pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        if (do_push && !do_pop) begin
            count_next = count_reg + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_reg[gi] <= '0;
            end else if (do_push && (wr_ptr_reg == PtrWidth'(gi))) begin
                mem_reg[gi] <= data_i;
            end
        end
    end

    assign data_o  = mem_reg[rd_ptr_reg];
    assign empty_o = (count_reg == '0);

endmodule

// File: rtl/spatz_tcdm_adapter.sv
// Converts Spatz x_mem requests into TCDM requests and returns in-order results.
module spatz_tcdm_adapter
    import spatz_tcdm_adapter_pkg::*;
#(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned NrOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   mem_valid_i,
    output logic                   mem_ready_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic                   mem_we_i,
    input  logic [1:0]             mem_size_i,
    input  logic [DataWidth/8-1:0] mem_be_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [IdWidth-1:0]     mem_id_i,
    output logic                   mem_exc_o,
    output logic [5:0]             mem_exccode_o,
    output logic                   mem_result_valid_o,
    output logic [IdWidth-1:0]     mem_result_id_o,
    output logic [DataWidth-1:0]   mem_result_rdata_o,
    output logic                   mem_result_err_o,
    output logic                   tcdm_q_valid_o,
    input  logic                   tcdm_q_ready_i,
    output logic [AddrWidth-1:0]   tcdm_q_addr_o,
    output logic                   tcdm_q_write_o,
    output logic [DataWidth/8-1:0] tcdm_q_strb_o,
    output logic [DataWidth-1:0]   tcdm_q_data_o,
    input  logic                   tcdm_p_valid_i,
    input  logic [DataWidth-1:0]   tcdm_p_data_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned MaxSize   = $clog2(StrbWidth);
    localparam int unsigned CntWidth  = $clog2(NrOutstanding + 1);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [StrbWidth-1:0] strb;
        logic [DataWidth-1:0] data;
    } tcdm_req_t;

    typedef struct packed {
        logic                 valid;
        logic [DataWidth-1:0] data;
    } tcdm_rsp_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               we;
    } meta_t;

    state_e             state_reg, state_next;
    logic [CntWidth-1:0] cnt_reg, cnt_next;
    logic [IdWidth-1:0] err_id_reg;
    logic               aligned;
    logic               req_fire;
    logic               err_accept;
    logic               fifo_empty;
    meta_t              meta_push, meta_head;
    tcdm_req_t          tcdm_req;
    tcdm_rsp_t          tcdm_rsp;

    assign aligned       = is_aligned(mem_addr_i[2:0], mem_size_i, MaxSize);
    assign tcdm_rsp      = '{valid: tcdm_p_valid_i, data: tcdm_p_data_i};
    assign meta_push     = '{id: mem_id_i, we: mem_we_i};

    always_comb begin
        state_next         = state_reg;
        mem_ready_o        = 1'b0;
        mem_exc_o          = 1'b0;
        mem_exccode_o      = '0;
        tcdm_q_valid_o     = 1'b0;
        err_accept         = 1'b0;
        mem_result_valid_o = 1'b0;
        mem_result_id_o    = '0;
        mem_result_rdata_o = '0;
        mem_result_err_o   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (mem_valid_i) begin
                    if (aligned) begin
                        tcdm_q_valid_o = (cnt_reg < CntWidth'(NrOutstanding));
                        mem_ready_o    = tcdm_q_valid_o && tcdm_q_ready_i;
                    end else begin
                        // Waiting for the FIFO to drain keeps the error result in order.
                        mem_ready_o = fifo_empty;
                        if (fifo_empty) begin
                            err_accept    = 1'b1;
                            mem_exc_o     = 1'b1;
                            mem_exccode_o = mem_we_i ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                            state_next    = ST_ERR;
                        end
                    end
                end
                if (tcdm_rsp.valid) begin
                    mem_result_valid_o = 1'b1;
                    mem_result_id_o    = meta_head.id;
                    mem_result_rdata_o = meta_head.we ? '0 : tcdm_rsp.data;
                end
            end
            ST_ERR: begin
                mem_result_valid_o = 1'b1;
                mem_result_id_o    = err_id_reg;
                mem_result_err_o   = 1'b1;
                state_next         = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign req_fire = tcdm_q_valid_o && tcdm_q_ready_i;

    always_comb begin
        tcdm_req = '0;
        if (tcdm_q_valid_o) begin
            tcdm_req = '{addr: mem_addr_i, write: mem_we_i, strb: mem_be_i, data: mem_wdata_i};
        end
    end

    assign tcdm_q_addr_o  = tcdm_req.addr;
    assign tcdm_q_write_o = tcdm_req.write;
    assign tcdm_q_strb_o  = tcdm_req.strb;
    assign tcdm_q_data_o  = tcdm_req.data;

    always_comb begin
        unique case ({req_fire, tcdm_p_valid_i})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            err_id_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (err_accept) begin
                err_id_reg <= mem_id_i;
            end
        end
    end

    spatz_tcdm_adapter_fifo #(
        .Width ($bits(meta_t)),
        .Depth (NrOutstanding)
    ) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (req_fire),
        .data_i  (meta_push),
        .pop_i   (tcdm_p_valid_i),
        .data_o  (meta_head),
        .empty_o (fifo_empty)
    );

    p_valid_needs_pending: assert property (
        @(posedge clk_i) disable iff (!rst_ni) tcdm_p_valid_i |-> !fifo_empty);

endmodule

// File: tb/tb_spatz_tcdm_adapter.sv
// Directed bench for spatz_tcdm_adapter: loads, stores, backpressure, misalignment, reset.
module tb_spatz_tcdm_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [31:0] mem_addr_i;
    logic        mem_we_i;
    logic [1:0]  mem_size_i;
    logic [3:0]  mem_be_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_id_i;
    logic        mem_exc_o;
    logic [5:0]  mem_exccode_o;
    logic        mem_result_valid_o;
    logic [3:0]  mem_result_id_o;
    logic [31:0] mem_result_rdata_o;
    logic        mem_result_err_o;
    logic        tcdm_q_valid_o;
    logic        tcdm_q_ready_i;
    logic [31:0] tcdm_q_addr_o;
    logic        tcdm_q_write_o;
    logic [3:0]  tcdm_q_strb_o;
    logic [31:0] tcdm_q_data_o;
    logic        tcdm_p_valid_i;
    logic [31:0] tcdm_p_data_i;

    int n_checks = 0;
    int n_pass   = 0;

    spatz_tcdm_adapter #(
        .DataWidth     (32),
        .AddrWidth     (32),
        .IdWidth       (4),
        .NrOutstanding (4)
    ) dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .mem_valid_i        (mem_valid_i),
        .mem_ready_o        (mem_ready_o),
        .mem_addr_i         (mem_addr_i),
        .mem_we_i           (mem_we_i),
        .mem_size_i         (mem_size_i),
        .mem_be_i           (mem_be_i),
        .mem_wdata_i        (mem_wdata_i),
        .mem_id_i           (mem_id_i),
        .mem_exc_o          (mem_exc_o),
        .mem_exccode_o      (mem_exccode_o),
        .mem_result_valid_o (mem_result_valid_o),
        .mem_result_id_o    (mem_result_id_o),
        .mem_result_rdata_o (mem_result_rdata_o),
        .mem_result_err_o   (mem_result_err_o),
        .tcdm_q_valid_o     (tcdm_q_valid_o),
        .tcdm_q_ready_i     (tcdm_q_ready_i),
        .tcdm_q_addr_o      (tcdm_q_addr_o),
        .tcdm_q_write_o     (tcdm_q_write_o),
        .tcdm_q_strb_o      (tcdm_q_strb_o),
        .tcdm_q_data_o      (tcdm_q_data_o),
        .tcdm_p_valid_i     (tcdm_p_valid_i),
        .tcdm_p_data_i      (tcdm_p_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
            $display("ok   %s = 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic [3:0] be, input logic [31:0] wd, input logic [3:0] id);
        mem_valid_i = 1'b1;
        mem_addr_i  = a;
        mem_we_i    = we;
        mem_size_i  = sz;
        mem_be_i    = be;
        mem_wdata_i = wd;
        mem_id_i    = id;
        #1;
    endtask

    task automatic resp(input logic [31:0] d);
        tcdm_p_valid_i = 1'b1;
        tcdm_p_data_i  = d;
        #1;
    endtask

    task automatic clear();
        mem_valid_i    = 1'b0;
        mem_addr_i     = '0;
        mem_we_i       = 1'b0;
        mem_size_i     = '0;
        mem_be_i       = '0;
        mem_wdata_i    = '0;
        mem_id_i       = '0;
        tcdm_p_valid_i = 1'b0;
        tcdm_p_data_i  = '0;
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, {mem_ready_o, mem_exc_o, mem_exccode_o, mem_result_valid_o,
                               mem_result_id_o, mem_result_err_o, tcdm_q_valid_o,
                               tcdm_q_write_o, tcdm_q_strb_o}, 64'h0);
        check({tag, "_data"}, {tcdm_q_addr_o, tcdm_q_data_o}, 64'h0);
        check({tag, "_rdata"}, mem_result_rdata_o, 64'h0);
    endtask

    initial begin
        rst_ni         = 1'b0;
        tcdm_q_ready_i = 1'b0;
        clear();
        check_reset_outputs("por");
        tick();
        tick();
        rst_ni = 1'b1;
        tcdm_q_ready_i = 1'b1;
        tick();

        // Single aligned load, response one cycle later.
        req(32'h100, 1'b0, 2'd2, 4'hF, 32'h0, 4'd3);
        check("ld_q_valid", tcdm_q_valid_o, 1);
        check("ld_q_addr", tcdm_q_addr_o, 32'h100);
        check("ld_q_write", tcdm_q_write_o, 0);
        check("ld_ready", mem_ready_o, 1);
        check("ld_exc", mem_exc_o, 0);
        tick();
        clear();
        resp(32'hDEADBEEF);
        check("ld_res", {mem_result_valid_o, mem_result_id_o, mem_result_err_o}, {1'b1, 4'd3, 1'b0});
        check("ld_rdata", mem_result_rdata_o, 32'hDEADBEEF);
        tick();
        clear();
        check("ld_res_idle", mem_result_valid_o, 0);

        // Single aligned store; response data must not leak into rdata.
        req(32'h104, 1'b1, 2'd2, 4'hF, 32'h12345678, 4'd5);
        check("st_q", {tcdm_q_valid_o, tcdm_q_write_o, tcdm_q_strb_o}, {1'b1, 1'b1, 4'hF});
        check("st_q_data", tcdm_q_data_o, 32'h12345678);
        check("st_q_addr", tcdm_q_addr_o, 32'h104);
        tick();
        clear();
        resp(32'hAAAA5555);
        check("st_res", {mem_result_valid_o, mem_result_id_o, mem_result_err_o}, {1'b1, 4'd5, 1'b0});
        check("st_rdata", mem_result_rdata_o, 0);
        tick();
        clear();

        // Five back-to-back loads with responses withheld: the fifth waits.
        for (int i = 0; i < 4; i++) begin
            req(32'h300 + 32'(4 * i), 1'b0, 2'd2, 4'hF, 32'h0, 4'(i));
            check($sformatf("b2b_ready%0d", i), mem_ready_o, 1);
            tick();
        end
        req(32'h310, 1'b0, 2'd2, 4'hF, 32'h0, 4'd4);
        check("full_ready", mem_ready_o, 0);
        check("full_q_valid", tcdm_q_valid_o, 0);
        tick();
        check("full_ready_hold", mem_ready_o, 0);
        resp(32'h1000);
        check("full_res_id0", {mem_result_valid_o, mem_result_id_o}, {1'b1, 4'd0});
        check("full_rdata0", mem_result_rdata_o, 32'h1000);
        check("full_ready_on_pop", mem_ready_o, 0);
        tick();
        tcdm_p_valid_i = 1'b0;
        #1;
        check("full_ready_after_pop", mem_ready_o, 1);
        tick();
        clear();
        for (int i = 1; i < 5; i++) begin
            resp(32'h1000 + 32'(i));
            check($sformatf("drain_id%0d", i), {mem_result_valid_o, mem_result_id_o}, {1'b1, 4'(i)});
            check($sformatf("drain_rdata%0d", i), mem_result_rdata_o, 32'h1000 + 32'(i));
            tick();
        end
        clear();

        // Misaligned load, FIFO empty.
        req(32'h102, 1'b0, 2'd2, 4'hF, 32'h0, 4'd7);
        check("mal_ld_acc", {mem_ready_o, mem_exc_o, mem_exccode_o}, {1'b1, 1'b1, 6'd4});
        check("mal_ld_no_q", tcdm_q_valid_o, 0);
        tick();
        req(32'h100, 1'b0, 2'd2, 4'hF, 32'h0, 4'd1);
        check("mal_ld_res", {mem_result_valid_o, mem_result_id_o, mem_result_err_o}, {1'b1, 4'd7, 1'b1});
        check("mal_ld_rdata", mem_result_rdata_o, 0);
        check("err_blocks", {mem_ready_o, tcdm_q_valid_o}, 2'b00);
        clear();
        tick();
        check("mal_ld_res_idle", mem_result_valid_o, 0);

        // Misaligned store (halfword at odd address).
        req(32'h101, 1'b1, 2'd1, 4'h3, 32'h0, 4'd9);
        check("mal_st_acc", {mem_ready_o, mem_exc_o, mem_exccode_o, tcdm_q_valid_o}, {1'b1, 1'b1, 6'd6, 1'b0});
        tick();
        clear();
        check("mal_st_res", {mem_result_valid_o, mem_result_id_o, mem_result_err_o}, {1'b1, 4'd9, 1'b1});
        tick();

        // Size larger than the data path is misaligned even at an aligned address.
        req(32'h108, 1'b0, 2'd3, 4'hF, 32'h0, 4'd2);
        check("oversize_acc", {mem_ready_o, mem_exc_o, mem_exccode_o, tcdm_q_valid_o}, {1'b1, 1'b1, 6'd4, 1'b0});
        tick();
        clear();
        check("oversize_res", {mem_result_valid_o, mem_result_id_o, mem_result_err_o}, {1'b1, 4'd2, 1'b1});
        tick();

        // Misaligned request behind two outstanding loads.
        req(32'h400, 1'b0, 2'd2, 4'hF, 32'h0, 4'd1);
        tick();
        req(32'h404, 1'b0, 2'd2, 4'hF, 32'h0, 4'd2);
        tick();
        req(32'h103, 1'b0, 2'd1, 4'h3, 32'h0, 4'd8);
        check("mal_wait", {mem_ready_o, mem_exc_o, tcdm_q_valid_o}, 3'b000);
        resp(32'h11);
        check("mal_wait_res1", {mem_result_valid_o, mem_result_id_o, mem_result_rdata_o}, {1'b1, 4'd1, 32'h11});
        check("mal_wait_ready1", mem_ready_o, 0);
        tick();
        resp(32'h22);
        check("mal_wait_res2", {mem_result_valid_o, mem_result_id_o, mem_result_rdata_o}, {1'b1, 4'd2, 32'h22});
        check("mal_wait_ready2", mem_ready_o, 0);
        tick();
        tcdm_p_valid_i = 1'b0;
        #1;
        check("mal_drained_acc", {mem_ready_o, mem_exc_o, mem_exccode_o}, {1'b1, 1'b1, 6'd4});
        tick();
        clear();
        check("mal_drained_res", {mem_result_valid_o, mem_result_id_o, mem_result_err_o}, {1'b1, 4'd8, 1'b1});
        tick();

        // Reset with three loads outstanding, then a full fresh burst.
        for (int i = 1; i < 4; i++) begin
            req(32'h500 + 32'(4 * i), 1'b0, 2'd2, 4'hF, 32'h0, 4'(i));
            tick();
        end
        clear();
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            req(32'h600 + 32'(4 * i), 1'b0, 2'd2, 4'hF, 32'h0, 4'(10 + i));
            check($sformatf("post_rst_ready%0d", i), mem_ready_o, 1);
            tick();
        end
        clear();
        for (int i = 0; i < 4; i++) begin
            resp(32'hC0DE0000 + 32'(i));
            check($sformatf("post_rst_res%0d", i), {mem_result_valid_o, mem_result_id_o, mem_result_err_o},
                  {1'b1, 4'(10 + i), 1'b0});
            check($sformatf("post_rst_rdata%0d", i), mem_result_rdata_o, 32'hC0DE0000 + 32'(i));
            tick();
        end
        clear();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
